// File: rtl/fsk_tx_ctrl.sv
// Byte-to-FSK frame controller: turns each accepted byte into a start bit, eight
// LSB-first data bits and a stop bit, each held on fsk_sel for SYM_CYCLES clocks.
module fsk_tx_ctrl #(
   parameter int unsigned SYM_CYCLES = 10000,
   parameter logic        IDLE_SEL   = 1'b1
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic       en,
   input  logic [7:0] s_data,
   input  logic       s_valid,
   output logic       s_ready,
   output logic       fsk_sel,
   output logic       tx_busy,
   output logic       sym_strobe,
   output logic       tx_done
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   localparam logic [15:0] SYM_LAST = 16'(SYM_CYCLES - 1);

   logic [1:0]  state;
   logic [15:0] sym_cnt;
   logic [2:0]  bit_cnt;
   logic [7:0]  shreg;
   logic        sym_last;
   logic        accept;

   assign sym_last = (sym_cnt == SYM_LAST);
   // A new byte can only be taken while idle or on the final stop cycle, so frames abut.
   assign s_ready  = !sys_rst && en &&
                     ((state == ST_IDLE) || ((state == ST_STOP) && sym_last));
   assign accept   = s_valid && s_ready;
   assign tx_done  = !sys_rst && (state == ST_STOP) && sym_last;

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state      <= ST_IDLE;
         sym_cnt    <= '0;
         bit_cnt    <= '0;
         shreg      <= '0;
         fsk_sel    <= IDLE_SEL;
         tx_busy    <= 1'b0;
         sym_strobe <= 1'b0;
      end else begin
         sym_strobe <= 1'b0;
         if (state == ST_IDLE) begin
            if (accept) begin
               state      <= ST_START;
               sym_cnt    <= '0;
               shreg      <= s_data;
               fsk_sel    <= 1'b0;
               tx_busy    <= 1'b1;
               sym_strobe <= 1'b1;
            end
         end else if (!sym_last) begin
            sym_cnt <= sym_cnt + 16'd1;
         end else begin
            sym_cnt    <= '0;
            sym_strobe <= 1'b1;
            case (state)
               ST_START: begin
                  state   <= ST_DATA;
                  bit_cnt <= '0;
                  fsk_sel <= shreg[0];
                  shreg   <= shreg >> 1;
               end
               ST_DATA: begin
                  if (bit_cnt == 3'd7) begin
                     state   <= ST_STOP;
                     fsk_sel <= 1'b1;
                  end else begin
                     bit_cnt <= bit_cnt + 3'd1;
                     fsk_sel <= shreg[0];
                     shreg   <= shreg >> 1;
                  end
               end
               ST_STOP: begin
                  if (accept) begin
                     state   <= ST_START;
                     shreg   <= s_data;
                     fsk_sel <= 1'b0;
                  end else begin
                     state      <= ST_IDLE;
                     fsk_sel    <= IDLE_SEL;
                     tx_busy    <= 1'b0;
                     sym_strobe <= 1'b0;
                  end
               end
               default: begin
                  state <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fsk_tx_ctrl.sv
// Bench for fsk_tx_ctrl: two instances (4 and 2 cycles per symbol) driven in lockstep
// and compared every cycle against a frame-timeline reference model.
module tb_fsk_tx_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, en, s_valid;
   logic [7:0] s_data;
   logic       rdy_a, sel_a, busy_a, stb_a, done_a;
   logic       rdy_b, sel_b, busy_b, stb_b, done_b;

   fsk_tx_ctrl #(.SYM_CYCLES(4), .IDLE_SEL(1'b1)) dut_a (
      .sys_clk(clk), .sys_rst(rst), .en(en), .s_data(s_data), .s_valid(s_valid),
      .s_ready(rdy_a), .fsk_sel(sel_a), .tx_busy(busy_a), .sym_strobe(stb_a), .tx_done(done_a));

   fsk_tx_ctrl #(.SYM_CYCLES(2), .IDLE_SEL(1'b1)) dut_b (
      .sys_clk(clk), .sys_rst(rst), .en(en), .s_data(s_data), .s_valid(s_valid),
      .s_ready(rdy_b), .fsk_sel(sel_b), .tx_busy(busy_b), .sym_strobe(stb_b), .tx_done(done_b));

   int total = 0;
   int bad   = 0;

   // Model: a frame is a 10*S-cycle window starting after the accept; position k in it
   // selects symbol k/S whose tone is 0 (start), byte bit, or 1 (stop).
   int         sc[2] = '{4, 2};
   bit         m_busy[2];
   int         m_k[2];
   logic [7:0] m_byte[2];

   function automatic logic [4:0] model_out(int i, logic r, logic e);
      logic rdy, sel, busy, stb, done;
      int   sym;
      if (m_busy[i]) begin
         sym  = m_k[i] / sc[i];
         sel  = (sym == 0) ? 1'b0 : (sym == 9) ? 1'b1 : m_byte[i][sym-1];
         busy = 1'b1;
         stb  = (m_k[i] % sc[i] == 0);
         done = (m_k[i] == 10 * sc[i] - 1);
      end else begin
         sel  = 1'b1;
         busy = 1'b0;
         stb  = 1'b0;
         done = 1'b0;
      end
      rdy  = !r && e && (!m_busy[i] || done);
      done = done && !r;
      return {rdy, sel, busy, stb, done};
   endfunction

   function automatic void model_step(int i, logic r, logic v, logic [7:0] d, logic rdy);
      if (r) begin
         m_busy[i] = 1'b0;
      end else if (v && rdy) begin
         m_busy[i] = 1'b1;
         m_k[i]    = 0;
         m_byte[i] = d;
      end else if (m_busy[i]) begin
         if (m_k[i] == 10 * sc[i] - 1) m_busy[i] = 1'b0;
         else m_k[i] = m_k[i] + 1;
      end
   endfunction

   // Drives one clock cycle, returns expected/observed output vectors for both instances
   // and whether instance A is expected to take the byte on the coming edge.
   task automatic cycle(input logic r, input logic e, input logic v, input logic [7:0] d,
                        output logic [4:0] ea, output logic [4:0] aa,
                        output logic [4:0] eb, output logic [4:0] ab, output logic acc);
      @(negedge clk);
      rst = r; en = e; s_valid = v; s_data = d;
      #1;
      ea = model_out(0, r, e);
      eb = model_out(1, r, e);
      aa = {rdy_a, sel_a, busy_a, stb_a, done_a};
      ab = {rdy_b, sel_b, busy_b, stb_b, done_b};
      acc = v && ea[4];
      model_step(0, r, v, d, ea[4]);
      model_step(1, r, v, d, eb[4]);
   endtask

   task automatic test_reset();
      logic [4:0] ea, aa, eb, ab;
      logic       acc;
      for (int c = 0; c < 6; c++) begin
         cycle(1'b1, 1'b1, 1'b1, 8'h5A, ea, aa, eb, ab, acc);
         total += 2;
         if (aa !== ea || aa !== 5'b01000) begin
            bad++;
            $display("FAIL reset_a cyc=%0d got=%b exp=%b", c, aa, ea);
         end
         if (ab !== eb) begin
            bad++;
            $display("FAIL reset_b cyc=%0d got=%b exp=%b", c, ab, eb);
         end
      end
   endtask

   task automatic test_single();
      logic [4:0] ea, aa, eb, ab;
      logic       acc;
      int         n_stb, n_done, done_at;
      n_stb = 0; n_done = 0; done_at = -1;
      for (int c = 0; c < 50; c++) begin
         cycle(1'b0, 1'b1, (c == 0), 8'hA5, ea, aa, eb, ab, acc);
         total += 2;
         if (aa !== ea) begin
            bad++;
            $display("FAIL single_a cyc=%0d got=%b exp=%b", c, aa, ea);
         end
         if (ab !== eb) begin
            bad++;
            $display("FAIL single_b cyc=%0d got=%b exp=%b", c, ab, eb);
         end
         n_stb  += int'(aa[1]);
         n_done += int'(aa[0]);
         if (aa[0] === 1'b1) done_at = c;
      end
      total += 2;
      if (n_stb != 10) begin
         bad++;
         $display("FAIL single_strobes got=%0d exp=10", n_stb);
      end
      if (n_done != 1 || done_at != 40) begin
         bad++;
         $display("FAIL single_done count=%0d at=%0d exp count=1 at=40", n_done, done_at);
      end
   endtask

   task automatic test_back_to_back();
      logic [4:0] ea, aa, eb, ab;
      logic       acc;
      logic [7:0] d;
      int         n_acc, busy_run, first_done, second_done;
      d = 8'h00; n_acc = 0; busy_run = 0; first_done = -1; second_done = -1;
      for (int c = 0; c < 100; c++) begin
         cycle(1'b0, 1'b1, (n_acc < 2), d, ea, aa, eb, ab, acc);
         total += 2;
         if (aa !== ea) begin
            bad++;
            $display("FAIL b2b_a cyc=%0d got=%b exp=%b", c, aa, ea);
         end
         if (ab !== eb) begin
            bad++;
            $display("FAIL b2b_b cyc=%0d got=%b exp=%b", c, ab, eb);
         end
         if (aa[2] === 1'b1) busy_run++;
         if (aa[0] === 1'b1) begin
            if (first_done < 0) first_done = c;
            else second_done = c;
         end
         if (acc) begin
            n_acc++;
            d = 8'hFF;
         end
      end
      total += 2;
      if (busy_run != 80) begin
         bad++;
         $display("FAIL b2b_busy got=%0d exp=80", busy_run);
      end
      if (second_done - first_done != 40) begin
         bad++;
         $display("FAIL b2b_done_gap got=%0d exp=40", second_done - first_done);
      end
   endtask

   task automatic test_en_drop();
      logic [4:0] ea, aa, eb, ab;
      logic       acc;
      for (int c = 0; c < 60; c++) begin
         cycle(1'b0, (c <= 10), 1'b1, 8'h3C, ea, aa, eb, ab, acc);
         total += 2;
         if (aa !== ea) begin
            bad++;
            $display("FAIL en_drop_a cyc=%0d got=%b exp=%b", c, aa, ea);
         end
         if (ab !== eb) begin
            bad++;
            $display("FAIL en_drop_b cyc=%0d got=%b exp=%b", c, ab, eb);
         end
      end
   endtask

   task automatic test_rst_mid();
      logic [4:0] ea, aa, eb, ab;
      logic       acc;
      for (int c = 0; c < 65; c++) begin
         cycle((c == 15), 1'b1, (c == 0 || c == 17), (c < 17) ? 8'hC3 : 8'h81,
               ea, aa, eb, ab, acc);
         total += 2;
         if (aa !== ea) begin
            bad++;
            $display("FAIL rst_mid_a cyc=%0d got=%b exp=%b", c, aa, ea);
         end
         if (ab !== eb) begin
            bad++;
            $display("FAIL rst_mid_b cyc=%0d got=%b exp=%b", c, ab, eb);
         end
      end
   endtask

   task automatic test_random();
      logic [4:0] ea, aa, eb, ab;
      logic       acc, r, e, v;
      logic [7:0] d;
      for (int c = 0; c < 1500; c++) begin
         r = ($urandom_range(0, 99) == 0);
         e = ($urandom_range(0, 7) != 0);
         v = ($urandom_range(0, 2) != 0);
         d = 8'($urandom);
         cycle(r, e, v, d, ea, aa, eb, ab, acc);
         total += 2;
         if (aa !== ea) begin
            bad++;
            $display("FAIL random_a cyc=%0d got=%b exp=%b", c, aa, ea);
         end
         if (ab !== eb) begin
            bad++;
            $display("FAIL random_b cyc=%0d got=%b exp=%b", c, ab, eb);
         end
      end
   endtask

   task automatic drain();
      logic [4:0] ea, aa, eb, ab;
      logic       acc;
      for (int c = 0; c < 45; c++) begin
         cycle(1'b0, 1'b1, 1'b0, 8'h00, ea, aa, eb, ab, acc);
         total += 2;
         if (aa !== ea) begin
            bad++;
            $display("FAIL drain_a cyc=%0d got=%b exp=%b", c, aa, ea);
         end
         if (ab !== eb) begin
            bad++;
            $display("FAIL drain_b cyc=%0d got=%b exp=%b", c, ab, eb);
         end
      end
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; s_valid = 1'b0; s_data = 8'h00;
      for (int i = 0; i < 2; i++) begin
         m_busy[i] = 1'b0;
         m_k[i]    = 0;
         m_byte[i] = 8'h00;
      end
      @(posedge clk);
      test_reset();
      test_single();
      test_back_to_back();
      drain();
      test_en_drop();
      drain();
      test_rst_mid();
      drain();
      test_random();
      drain();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
